// File: rtl/scarv_cop_mem_responder.sv
// Target-side memory for the coprocessor memory bus: programmable wait states,
// byte-enabled writes, asynchronous read in the completion cycle, range-checked errors.
module scarv_cop_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  input  logic [3:0]  cfg_wait,
  output logic        busy
);

  localparam int          IDX_W = $clog2(DEPTH);
  // 33-bit limit so a window ending at 2^32 does not wrap
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  logic [3:0]         cnt_r;
  logic               req_wen_r;
  logic [IDX_W-1:0]   req_idx_r;
  logic [31:0]        req_wdata_r;
  logic [3:0]         req_ben_r;
  logic               req_in_range_r;
  logic               stall_r;
  logic               error_r;
  logic               busy_r;
  logic [31:0]        mem [DEPTH];

  logic [31:0]        offset_s;
  logic               in_range_s;
  logic               accept_s;
  logic               unused_addr_s;

  assign offset_s      = cop_mem_addr - BASE_ADDR;
  assign in_range_s    = (cop_mem_addr >= BASE_ADDR) && ({1'b0, cop_mem_addr} < LIMIT);
  assign accept_s      = cop_mem_cen && (state_r != WAIT);
  assign unused_addr_s = ^{offset_s[1:0], offset_s[31:IDX_W+2]};

  assign cop_mem_stall = stall_r;
  assign cop_mem_error = error_r;
  assign busy          = busy_r;

  // Request FSM: captures accepted requests, counts wait states, registers status outputs
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      req_wen_r      <= 1'b0;
      req_idx_r      <= '0;
      req_wdata_r    <= 32'h0;
      req_ben_r      <= 4'b0000;
      req_in_range_r <= 1'b0;
      stall_r        <= 1'b0;
      error_r        <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            req_wen_r      <= cop_mem_wen;
            req_idx_r      <= offset_s[IDX_W+1:2];
            req_wdata_r    <= cop_mem_wdata;
            req_ben_r      <= cop_mem_ben;
            req_in_range_r <= in_range_s;
            busy_r         <= 1'b1;
            if (cfg_wait == 4'd0) begin
              state_r <= DONE;
              cnt_r   <= 4'd0;
              stall_r <= 1'b0;
              error_r <= !in_range_s;
            end else begin
              state_r <= WAIT;
              cnt_r   <= cfg_wait;
              stall_r <= 1'b1;
              error_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            stall_r <= 1'b0;
            error_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd1) begin
            state_r <= DONE;
            cnt_r   <= 4'd0;
            stall_r <= 1'b0;
            error_r <= !req_in_range_r;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            stall_r <= 1'b1;
            error_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          stall_r <= 1'b0;
          error_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-enabled write commit at the edge that ends the completion cycle
  always_ff @(posedge g_clk) begin
    if ((state_r == DONE) && req_wen_r && req_in_range_r) begin
      for (int i = 0; i < 4; i++) begin
        if (req_ben_r[i]) begin
          mem[req_idx_r][8*i +: 8] <= req_wdata_r[8*i +: 8];
        end
      end
    end
  end

  // Read data is only driven during an in-range read completion
  always_comb begin
    cop_mem_rdata = 32'h0;
    if ((state_r == DONE) && !req_wen_r && req_in_range_r) begin
      cop_mem_rdata = mem[req_idx_r];
    end else begin
      cop_mem_rdata = 32'h0;
    end
  end

endmodule

// File: tb/tb_scarv_cop_mem_responder.sv
// Self-checking bench: directed vector table, multi-cycle sequences, and random
// traffic against a word-array reference model of the responder.
module tb_scarv_cop_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        g_clk;
  logic        g_resetn;
  logic        cop_mem_cen;
  logic        cop_mem_wen;
  logic [31:0] cop_mem_addr;
  logic [31:0] cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [31:0] cop_mem_rdata;
  logic        cop_mem_stall;
  logic        cop_mem_error;
  logic [3:0]  cfg_wait;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] mdl [DEPTH];

  scarv_cop_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .cop_mem_cen(cop_mem_cen),
    .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
    .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben),
    .cop_mem_rdata(cop_mem_rdata), .cop_mem_stall(cop_mem_stall),
    .cop_mem_error(cop_mem_error), .cfg_wait(cfg_wait), .busy(busy)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    logic [3:0]  wt;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  function automatic logic [31:0] pattern(int i);
    logic [7:0] b;
    b = 8'(i);
    return {16'hC0DE, b, ~b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: flat word array, range rule and byte-enable merge from plain arithmetic
  task automatic model_step(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ben, output logic [31:0] exp_rd, output bit exp_err);
    longint a;
    int idx;
    a = longint'(addr);
    exp_rd = 32'h0;
    exp_err = !((a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH));
    if (!exp_err) begin
      idx = int'((a - longint'(BASE)) / 4);
      if (wen) begin
        for (int b = 0; b < 4; b++)
          if (ben[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = mdl[idx];
      end
    end
  endtask

  // Issue one request at a negedge; return at the negedge of its completion cycle
  task automatic run_and_check(input string name, input bit wen, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] ben, input logic [3:0] w,
                               input logic [31:0] exp_rd, input bit exp_err);
    int stalls;
    bit done;
    cop_mem_cen = 1'b1; cop_mem_wen = wen; cop_mem_addr = addr;
    cop_mem_wdata = wd; cop_mem_ben = ben; cfg_wait = w;
    @(posedge g_clk);
    #1;
    cop_mem_cen = 1'b0;
    cop_mem_wen = 1'($urandom); cop_mem_addr = $urandom;
    cop_mem_wdata = $urandom; cop_mem_ben = 4'($urandom); cfg_wait = 4'($urandom);
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge g_clk);
      if (!cop_mem_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: stall still high after 40 cycles, required low", name);
    end else begin
      chk({name, "_stalls"}, 32'(stalls), 32'(w));
      chk({name, "_rdata"}, cop_mem_rdata, exp_rd);
      chk({name, "_error"}, 32'(cop_mem_error), 32'(exp_err));
      chk({name, "_busy"}, 32'(busy), 32'h1);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] e_rd;
    bit e_err;
    bit w;
    logic [31:0] a, d;
    logic [3:0] bn, wt;

    g_resetn = 1'b0; cop_mem_cen = 1'b0; cop_mem_wen = 1'b0; cop_mem_addr = 32'h0;
    cop_mem_wdata = 32'h0; cop_mem_ben = 4'b0000; cfg_wait = 4'd0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("reset_rdata", cop_mem_rdata, 32'h0);
    chk("reset_stall", 32'(cop_mem_stall), 32'h0);
    chk("reset_error", 32'(cop_mem_error), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    g_resetn = 1'b1;

    // Known initial contents
    for (int i = 0; i < DEPTH; i++) begin
      model_step(1'b1, BASE + 32'(4 * i), pattern(i), 4'b1111, e_rd, e_err);
      run_and_check("fill", 1'b1, BASE + 32'(4 * i), pattern(i), 4'b1111, 4'd0, e_rd, e_err);
    end

    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 4'd0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0, 4'b0000, 4'd0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10, 32'h00AA0000, 4'b0100, 4'd0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h10, 32'h0, 4'b0000, 4'd0, 32'hDEAABEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h10, 32'h0, 4'b0000, 4'd3, 32'hDEAABEEF, 1'b0};
    vecs[5]  = '{1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'b1111, 4'd0, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'b0000, 4'd0, pattern(DEPTH - 1), 1'b0};
    vecs[7]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 4'd0, pattern(0), 1'b0};
    vecs[8]  = '{1'b1, 32'h14, 32'h11223344, 4'b0000, 4'd2, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h14, 32'h0, 4'b0000, 4'd1, pattern(5), 1'b0};
    vecs[10] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'b0000, 4'd1, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 32'h13, 32'h0, 4'b1111, 4'd0, 32'hDEAABEEF, 1'b0};

    for (int i = 0; i < 12; i++) begin
      model_step(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].ben, e_rd, e_err);
      run_and_check($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                    vecs[i].ben, vecs[i].wt, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Back-to-back reads with cen held high: one completion per cycle
    cop_mem_cen = 1'b1; cop_mem_wen = 1'b0; cop_mem_addr = 32'h0; cfg_wait = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge g_clk);
      @(negedge g_clk);
      chk($sformatf("b2b%0d_rdata", k), cop_mem_rdata, pattern(k));
      chk($sformatf("b2b%0d_stall", k), 32'(cop_mem_stall), 32'h0);
      chk($sformatf("b2b%0d_error", k), 32'(cop_mem_error), 32'h0);
      if (k < 3) cop_mem_addr = 32'(4 * (k + 1));
      else cop_mem_cen = 1'b0;
    end
    @(negedge g_clk);
    chk("b2b_idle_busy", 32'(busy), 32'h0);

    // Reset during wait states drops the pending write
    cop_mem_cen = 1'b1; cop_mem_wen = 1'b1; cop_mem_addr = 32'h20;
    cop_mem_wdata = 32'h12345678; cop_mem_ben = 4'b1111; cfg_wait = 4'd5;
    @(posedge g_clk);
    #1 cop_mem_cen = 1'b0;
    @(negedge g_clk);
    chk("rstmid_stall_before", 32'(cop_mem_stall), 32'h1);
    @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    chk("rstmid_stall", 32'(cop_mem_stall), 32'h0);
    chk("rstmid_error", 32'(cop_mem_error), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
    model_step(1'b0, 32'h20, 32'h0, 4'b0000, e_rd, e_err);
    run_and_check("rstmid_read", 1'b0, 32'h20, 32'h0, 4'b0000, 4'd0, pattern(8), 1'b0);

    // Random traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        a = 32'(4 * DEPTH) + 32'($urandom_range(0, 32'h7FFF_FFFF));
      else
        a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      d  = $urandom;
      bn = 4'($urandom_range(0, 15));
      wt = 4'($urandom_range(0, 3));
      model_step(w, a, d, bn, e_rd, e_err);
      run_and_check($sformatf("rnd%0d", n), w, a, d, bn, wt, e_rd, e_err);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge g_clk);
        chk($sformatf("rnd%0d_idle_busy", n), 32'(busy), 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
